// File: rtl/sobel_stream_sequencer.sv
// Sobel edge custom-instruction controller: line buffers, 3x3 window and a
// four-pixel-per-PUSH |Gx|+|Gy| sequencer on the CPU CI bus.
module sobel_stream_sequencer #(
   parameter logic [7:0]  customId  = 8'h00,
   parameter int unsigned MAX_WIDTH = 640
) (
   input  logic        clock,
   input  logic        nReset,
   input  logic        start,
   input  logic [7:0]  ciN,
   input  logic [31:0] valueA,
   input  logic [31:0] valueB,
   output logic        done,
   output logic [31:0] result
);

   localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_PROC, S_DONE} state_e;
   typedef enum logic [1:0] {OP_CONFIG, OP_PUSH, OP_STATUS, OP_THRESH} op_e;

   state_e      state_q;
   logic [1:0]  k_q;
   logic [31:0] data_q;
   logic [31:0] acc_q;
   logic [10:0] width_q;
   logic [10:0] row_q;
   logic [10:0] col_q;
   logic [7:0]  thr_q;
   logic        done_q;
   logic [31:0] result_q;

   // Line buffers and window are deliberately unreset; row/col gating masks stale data.
   logic [7:0]  line_a_q [MAX_WIDTH];
   logic [7:0]  line_b_q [MAX_WIDTH];
   logic [7:0]  win_top_q [3];
   logic [7:0]  win_mid_q [3];
   logic [7:0]  win_bot_q [3];

   op_e         op;
   logic        accept;
   logic [10:0] cfg_w;
   logic        cfg_ok;
   logic        unused_bits;

   logic [AW-1:0] lb_idx;
   logic [7:0]    pix;
   logic [7:0]    rd_a;
   logic [7:0]    rd_b;
   logic [11:0]   sx_r, sx_l, sy_t, sy_b;
   logic [11:0]   dx, dy, mag;
   logic          win_ok;
   logic [7:0]    edge_byte;
   logic [31:0]   acc_d;
   logic          col_wrap;

   assign op          = op_e'(valueA[1:0]);
   assign accept      = start && (ciN == customId);
   assign cfg_w       = valueB[10:0];
   assign cfg_ok      = (cfg_w >= 11'd3) && (cfg_w <= 11'(MAX_WIDTH));
   assign unused_bits = ^valueA[31:2];

   assign lb_idx   = col_q[AW-1:0];
   assign rd_a     = line_b_q[lb_idx];
   assign rd_b     = line_a_q[lb_idx];
   assign col_wrap = (col_q == width_q - 11'd1);

   // Select the current pixel of the latched PUSH word, MSB byte first.
   always_comb begin
      case (k_q)
         2'd0:    pix = data_q[31:24];
         2'd1:    pix = data_q[23:16];
         2'd2:    pix = data_q[15:8];
         default: pix = data_q[7:0];
      endcase
   end

   // Sobel magnitude on the window as it will look after this pixel shifts in.
   always_comb begin
      // right column is the incoming {a,b,p}; left column is the current middle column
      sx_r = 12'(rd_a) + (12'(rd_b) << 1) + 12'(pix);
      sx_l = 12'(win_top_q[1]) + (12'(win_mid_q[1]) << 1) + 12'(win_bot_q[1]);
      sy_t = 12'(win_top_q[1]) + (12'(win_top_q[2]) << 1) + 12'(rd_a);
      sy_b = 12'(win_bot_q[1]) + (12'(win_bot_q[2]) << 1) + 12'(pix);
      dx   = (sx_r >= sx_l) ? (sx_r - sx_l) : (sx_l - sx_r);
      dy   = (sy_t >= sy_b) ? (sy_t - sy_b) : (sy_b - sy_t);
      mag  = dx + dy;
      win_ok = (row_q >= 11'd2) && (col_q >= 11'd2);
      if (!win_ok) begin
         edge_byte = 8'h00;
      end else if (thr_q == 8'h00) begin
         edge_byte = (mag > 12'd255) ? 8'hFF : mag[7:0];
      end else begin
         edge_byte = (mag >= 12'(thr_q)) ? 8'hFF : 8'h00;
      end
   end

   // Merge the current edge byte into its lane of the result word.
   always_comb begin
      acc_d = acc_q;
      case (k_q)
         2'd0:    acc_d[31:24] = edge_byte;
         2'd1:    acc_d[23:16] = edge_byte;
         2'd2:    acc_d[15:8]  = edge_byte;
         default: acc_d[7:0]   = edge_byte;
      endcase
   end

   // Line-buffer writes and window shift, one per PROC cycle.
   always_ff @(posedge clock) begin
      if (state_q == S_PROC) begin
         line_b_q[lb_idx] <= rd_b;
         line_a_q[lb_idx] <= pix;
         win_top_q[0] <= win_top_q[1];
         win_top_q[1] <= win_top_q[2];
         win_top_q[2] <= rd_a;
         win_mid_q[0] <= win_mid_q[1];
         win_mid_q[1] <= win_mid_q[2];
         win_mid_q[2] <= rd_b;
         win_bot_q[0] <= win_bot_q[1];
         win_bot_q[1] <= win_bot_q[2];
         win_bot_q[2] <= pix;
      end
   end

   // Control FSM: command decode, pixel sequencing, counters and registered outputs.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         data_q   <= '0;
         acc_q    <= '0;
         width_q  <= 11'(MAX_WIDTH);
         row_q    <= '0;
         col_q    <= '0;
         thr_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q   <= 1'b0;
               result_q <= '0;
               if (accept) begin
                  data_q <= valueB;
                  case (op)
                     OP_CONFIG: begin
                        if (cfg_ok) begin
                           width_q  <= cfg_w;
                           row_q    <= '0;
                           col_q    <= '0;
                           result_q <= '0;
                        end else begin
                           result_q <= 32'h1;
                        end
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end
                     OP_PUSH: begin
                        k_q     <= '0;
                        state_q <= S_PROC;
                     end
                     OP_STATUS: begin
                        result_q <= {5'b0, row_q, 5'b0, col_q};
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                     end
                     default: begin
                        thr_q    <= valueB[7:0];
                        result_q <= '0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                     end
                  endcase
               end
            end
            S_PROC: begin
               acc_q <= acc_d;
               if (col_wrap) begin
                  col_q <= '0;
                  if (row_q != 11'd2047) begin
                     row_q <= row_q + 11'd1;
                  end
               end else begin
                  col_q <= col_q + 11'd1;
               end
               k_q <= k_q + 2'd1;
               if (k_q == 2'd3) begin
                  result_q <= acc_d;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end
            end
            S_DONE: begin
               done_q   <= 1'b0;
               result_q <= '0;
               state_q  <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_sobel_stream_sequencer.sv
// Self-checking bench for sobel_stream_sequencer: image-level reference model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_sobel_stream_sequencer;

   logic        clock  = 1'b0;
   logic        nReset = 1'b1;
   logic        start  = 1'b0;
   logic [7:0]  ciN    = 8'h00;
   logic [31:0] valueA = '0;
   logic [31:0] valueB = '0;
   logic        done;
   logic [31:0] result;

   sobel_stream_sequencer #(
      .customId  (8'h00),
      .MAX_WIDTH (640)
   ) dut (
      .clock  (clock),
      .nReset (nReset),
      .start  (start),
      .ciN    (ciN),
      .valueA (valueA),
      .valueB (valueB),
      .done   (done),
      .result (result)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int          errors = 0;
   int          checks = 0;
   int          exp_cycle = -1;
   logic [31:0] exp_res = '0;
   logic [31:0] last_res = '0;
   int          done_cnt = 0;
   bit          cmp_en = 1'b0;
   logic        exp_d;

   // ---------------- image-level reference model ----------------
   int          m_width = 640;
   int          m_row = 0;
   int          m_col = 0;
   int          m_thr = 0;
   logic [7:0]  img [16][640];

   function automatic int px(input int r, input int c);
      return int'(img[r % 16][c]);
   endfunction

   function automatic logic [7:0] sobel(input int r, input int c);
      int gx, gy, mag;
      if (r < 2 || c < 2) return 8'h00;
      gx = (px(r-2,c) + 2*px(r-1,c) + px(r,c)) - (px(r-2,c-2) + 2*px(r-1,c-2) + px(r,c-2));
      gy = (px(r-2,c-2) + 2*px(r-2,c-1) + px(r-2,c)) - (px(r,c-2) + 2*px(r,c-1) + px(r,c));
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (m_thr == 0) return (mag > 255) ? 8'hFF : 8'(mag);
      return (mag >= m_thr) ? 8'hFF : 8'h00;
   endfunction

   task automatic model_reset();
      m_width = 640;
      m_row   = 0;
      m_col   = 0;
      m_thr   = 0;
   endtask

   task automatic model_exec(input int op, input logic [31:0] b,
                             output logic [31:0] res, output int lat);
      logic [10:0] w;
      logic [7:0]  p;
      res = '0;
      lat = 1;
      case (op)
         0: begin
            w = b[10:0];
            if (w >= 11'd3 && w <= 11'd640) begin
               m_width = int'(w);
               m_row = 0;
               m_col = 0;
            end else begin
               res = 32'h1;
            end
         end
         1: begin
            lat = 5;
            for (int k = 0; k < 4; k++) begin
               p = b[31-8*k -: 8];
               img[m_row % 16][m_col] = p;
               res[31-8*k -: 8] = sobel(m_row, m_col);
               if (m_col == m_width - 1) begin
                  m_col = 0;
                  if (m_row != 2047) m_row++;
               end else begin
                  m_col++;
               end
            end
         end
         2: res = {5'b0, 11'(m_row), 5'b0, 11'(m_col)};
         default: m_thr = int'(b[7:0]);
      endcase
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clock) begin
      if (cmp_en) begin
         exp_d = (cyc == exp_cycle);
         checks++;
         if (done !== exp_d || result !== (exp_d ? exp_res : 32'h0)) begin
            errors++;
            $display("FAIL cycle_check cyc=%0d: done=%0b result=%h, required done=%0b result=%h",
                     cyc, done, result, exp_d, exp_d ? exp_res : 32'h0);
         end
         if (done === 1'b1) begin
            done_cnt++;
            last_res = result;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input int op, input logic [31:0] b);
      logic [31:0] r;
      int lat;
      @(negedge clock);
      model_exec(op, b, r, lat);
      last_res  = 32'hDEAD_BEEF;
      exp_res   = r;
      exp_cycle = cyc + lat;
      start  = 1'b1;
      ciN    = 8'h00;
      valueA = 32'(op);
      valueB = b;
      @(negedge clock);
      start  = 1'b0;
      valueA = '0;
      valueB = '0;
      repeat (lat) @(negedge clock);
   endtask

   task automatic check_lit(input string name, input logic [31:0] want);
      checks++;
      if (last_res !== want) begin
         errors++;
         $display("FAIL %s: result=%h, required %h", name, last_res, want);
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   task automatic push3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      issue(1, a);
      issue(1, b);
      issue(1, c);
   endtask

   logic [31:0] words [8] = '{32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hFF00FF00,
                              32'h0F1E2D3C, 32'h80808080, 32'h01FE01FE, 32'h33CC66AA};

   initial begin
      int d0;
      logic [31:0] r;
      int lat;

      #1 nReset = 1'b0;
      repeat (2) @(negedge clock);
      cmp_en = 1'b1;
      repeat (2) @(negedge clock);
      nReset = 1'b1;
      model_reset();

      // reset state and CONFIG bounds
      issue(2, 32'h0);            check_lit("status_after_reset", 32'h0);
      issue(0, 32'd2);            check_lit("config_w2_reject", 32'h1);
      issue(0, 32'd641);          check_lit("config_w641_reject", 32'h1);
      issue(0, 32'd640);          check_lit("config_w640_accept", 32'h0);
      issue(1, 32'h01020304);
      issue(2, 32'h0);            check_lit("status_w640_one_push", 32'h00000004);
      issue(0, 32'd3);            check_lit("config_w3_accept", 32'h0);
      issue(2, 32'h0);            check_lit("status_after_config", 32'h0);

      // foreign ciN in IDLE is ignored
      @(negedge clock);
      start = 1'b1; ciN = 8'h5A; valueA = 32'd2;
      @(negedge clock);
      start = 1'b0; ciN = 8'h00; valueA = '0;
      repeat (3) @(negedge clock);

      // basic edge case W=4
      issue(0, 32'd4);
      issue(1, 32'h0);            check_lit("push_row0", 32'h0);
      issue(1, 32'h0);            check_lit("push_row1", 32'h0);
      issue(1, 32'h00006464);     check_lit("push_row2_sat", 32'h0000C8FF);

      // threshold modes
      issue(3, 32'd128);          check_lit("thresh128_ack", 32'h0);
      issue(0, 32'd4);
      push3(32'h0, 32'h0, 32'h00006464);
      check_lit("thresh128_edges", 32'h0000FFFF);
      issue(3, 32'd250);
      issue(0, 32'd4);
      push3(32'h0, 32'h0, 32'h00006464);
      check_lit("thresh250_edges", 32'h000000FF);
      issue(3, 32'd0);

      // row wrap across word boundaries, W=6
      issue(0, 32'd6);
      push3(32'h10203040, 32'h50607080, 32'h90A0B0C0);
      issue(2, 32'h0);            check_lit("status_w6_12px", 32'h00020000);

      // model-checked image, odd width and a threshold pass
      issue(0, 32'd7);
      for (int i = 0; i < 8; i++) issue(1, words[i]);
      issue(3, 32'd60);
      for (int i = 0; i < 4; i++) issue(1, words[7-i]);
      issue(3, 32'd0);
      issue(2, 32'h0);            check_lit("status_w7_48px", {5'b0, 11'd6, 5'b0, 11'd6});

      // starts during PROC and DONE are ignored
      d0 = done_cnt;
      @(negedge clock);
      model_exec(1, 32'h11223344, r, lat);
      exp_res   = r;
      exp_cycle = cyc + lat;
      start = 1'b1; ciN = 8'h00; valueA = 32'd1; valueB = 32'h11223344;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clock);
         start  = 1'b1;
         ciN    = (i % 2 == 1) ? 8'h00 : 8'hC3;
         valueA = (i % 2 == 1) ? 32'd2 : 32'd0;
         valueB = 32'd5;
      end
      @(negedge clock);
      start = 1'b0; ciN = 8'h00; valueA = '0; valueB = '0;
      repeat (3) @(negedge clock);
      check_int("one_done_with_starts_in_proc", done_cnt - d0, 1);

      // reset in the middle of a PUSH
      d0 = done_cnt;
      @(negedge clock);
      exp_cycle = -1;
      start = 1'b1; ciN = 8'h00; valueA = 32'd1; valueB = 32'hFFFFFFFF;
      @(negedge clock);
      start = 1'b0; valueA = '0; valueB = '0;
      @(negedge clock);
      nReset = 1'b0;
      model_reset();
      repeat (6) @(negedge clock);
      nReset = 1'b1;
      check_int("no_done_after_abort", done_cnt - d0, 0);
      issue(2, 32'h0);            check_lit("status_after_abort", 32'h0);

      repeat (2) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
